spi_ram_arbiter: RTL and testbench
==================================

// Module: spi_ram_arbiter
// PURPOSE
//  Shares one single-port 512x32 RAM between the SPI slave register bridge and a local
//  fabric master. SPI accesses are single-cycle pulses with no backpressure, so they always
//  win; the local master uses a req/gnt handshake. Sits between the SPI slave and the RAM.
// PARAMETERS
//  AW       9   RAM address width (word address)
//  DW       32  data width
//  RAM_LAT  1   RAM read latency in clk cycles, legal 1..3
// PORTS
//  clk          in   1   system clock, single clock domain
//  rst          in   1   synchronous, active-high reset
//  spi_base     in   15  SPI header address; bits [AW-1:0] are the base word
//  spi_wr_en    in   1   1-cycle SPI write pulse
//  spi_wr_addr  in   AW  SPI write offset from base
//  spi_wr_data  in   DW  SPI write data, valid with spi_wr_en
//  spi_rd_en    in   1   1-cycle SPI read pulse
//  spi_rd_addr  in   AW  SPI read offset from base
//  spi_rd_data  out  DW  read data returned to SPI, held until next SPI read returns
//  loc_req      in   1   local request, held high until loc_gnt
//  loc_we       in   1   1=write, 0=read; stable while loc_req
//  loc_addr     in   AW  local absolute word address
//  loc_wdata    in   DW  local write data
//  loc_gnt      out  1   1-cycle grant; request consumed this cycle
//  loc_rvalid   out  1   1-cycle pulse, loc_rdata valid
//  loc_rdata    out  DW  local read data
//  ram_en/ram_we out 1   RAM enable / write enable (registered)
//  ram_addr     out  AW  RAM address (registered)
//  ram_wdata    out  DW  RAM write data (registered)
//  ram_rdata    in   DW  RAM read data, RAM_LAT cycles after ram_en&!ram_we
//  spi_ovf      out  1   sticky: SPI pulse arrived while same-type slot still pending
// BEHAVIOUR
//  Reset: all outputs 0, pending slots empty, state ARB. spi_ovf cleared only by rst.
//  SPI pulses captured into two pending slots (WR, RD) in the cycle they arrive; physical
//   address = spi_base[AW-1:0] + offset, modulo 2^AW (wraps 511->0, no carry out).
//  FSM states ARB, G_SPI_WR, G_SPI_RD, G_LOC; each grant state lasts exactly 1 cycle and
//   returns to ARB; ARB may re-grant the very next cycle (one access per 2 cycles max).
//  ARB priority: WR slot > RD slot > loc_req. Grant cycle drives ram_* regs; next cycle
//   ram_en is seen by RAM.
//  loc_gnt pulses in the G_LOC cycle; local sees no grant while any SPI slot is pending.
//  Read return: RAM_LAT+1-deep tag shift register (valid, owner). SPI owner -> spi_rd_data
//   loaded; LOC owner -> loc_rdata loaded and loc_rvalid pulses. Total latency from grant
//   to data = RAM_LAT+1 cycles.
//  Simultaneous spi_wr_en and spi_rd_en: both captured; write served first.
//  Pulse into occupied slot of same type: new request overwrites, spi_ovf set.
//  Pulse in the same cycle its slot is being granted: the grant takes the old one, new one
//   is captured, no overflow.
//  rst mid-operation: pending slots and tag pipe flushed, in-flight reads dropped, no
//   loc_rvalid after rst.
// STRUCTURE
//  Shared package spi_ram_pkg: AW/DW defaults, FSM state encoding (one-hot, 4 states),
//   owner tag constants OWN_SPI=1'b0 / OWN_LOC=1'b1.
//  Sub-module spi_ram_rtag_pipe: parameterised RAM_LAT tag/valid shift register.
//  Top holds pending slots, address adder, FSM, output registers.
// TESTING
//  SPI write: base=0x1F0, spi_wr_en off=0x020, data 0xDEADBEEF -> ram_we at addr 0x010 (wrap).
//  SPI read: base=0, off=5, RAM word5=0x12345678 -> spi_rd_data=0x12345678 at grant+RAM_LAT+1.
//  Contention: loc_req write + spi_wr_en same cycle -> SPI granted first, loc_gnt 2 cycles later.
//  Local read addr 0x1FF, RAM_LAT=2 -> loc_rvalid exactly 3 cycles after loc_gnt, correct data.
//  Two spi_wr_en pulses on consecutive cycles while RD slot is granting -> spi_ovf=1, last data kept.
//  rst asserted 1 cycle after local read grant -> no loc_rvalid, all outputs 0 next cycle.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI / local-master RAM arbiter.
package spi_ram_pkg;

    localparam int unsigned AW_DEF = 9;
    localparam int unsigned DW_DEF = 32;

    localparam logic OWN_SPI = 1'b0;
    localparam logic OWN_LOC = 1'b1;

    typedef enum logic [3:0] {
        StArb    = 4'b0001,
        StGSpiWr = 4'b0010,
        StGSpiRd = 4'b0100,
        StGLoc   = 4'b1000
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic own;
    } rtag_t;

endpackage

// File: rtl/spi_ram_rtag_pipe.sv
// Read-return tag pipe: one (valid, owner) entry per grant cycle, RAM_LAT+1 stages deep so the
// last stage lines up with ram_rdata.
module spi_ram_rtag_pipe
    import spi_ram_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic own_i,
    output logic vld_o,
    output logic own_o
);

    localparam int unsigned Depth = RAM_LAT + 1;

    rtag_t pipe_q [Depth];
    rtag_t pipe_d [Depth];

    always_comb begin
        pipe_d[0] = {push_i, own_i};
        for (int i = 1; i < Depth; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign vld_o = pipe_q[Depth-1].vld;
    assign own_o = pipe_q[Depth-1].own;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between SPI register-bridge pulses (always win) and a local
// req/gnt master. One RAM access per two cycles; read data routed back by owner tag.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [14:0]   spi_base_i,
    input  logic          spi_wr_en_i,
    input  logic [AW-1:0] spi_wr_addr_i,
    input  logic [DW-1:0] spi_wr_data_i,
    input  logic          spi_rd_en_i,
    input  logic [AW-1:0] spi_rd_addr_i,
    output logic [DW-1:0] spi_rd_data_o,
    input  logic          loc_req_i,
    input  logic          loc_we_i,
    input  logic [AW-1:0] loc_addr_i,
    input  logic [DW-1:0] loc_wdata_i,
    output logic          loc_gnt_o,
    output logic          loc_rvalid_o,
    output logic [DW-1:0] loc_rdata_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          spi_ovf_o
);

    arb_state_e    state_q, state_d;

    logic          wr_vld_q, wr_vld_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          spi_ovf_q, spi_ovf_d;

    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic [DW-1:0] spi_rd_data_q, spi_rd_data_d;
    logic [DW-1:0] loc_rdata_q, loc_rdata_d;

    logic          wr_grant, rd_grant, loc_grant;
    logic          tag_push, tag_own_in, tag_vld, tag_own;
    logic          spi_hit, loc_hit;
    logic [AW-1:0] base;
    logic          unused_base;

    assign base        = spi_base_i[AW-1:0];
    assign unused_base = ^spi_base_i[14:AW];

    assign wr_grant  = (state_q == StGSpiWr);
    assign rd_grant  = (state_q == StGSpiRd);
    assign loc_grant = (state_q == StGLoc);

    // A pulse landing on its own slot's grant cycle is a fresh request, not an overflow.
    always_comb begin
        wr_vld_d  = wr_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        spi_ovf_d = spi_ovf_q;
        if (wr_grant) wr_vld_d = 1'b0;
        if (rd_grant) rd_vld_d = 1'b0;
        if (spi_wr_en_i) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = base + spi_wr_addr_i;
            wr_data_d = spi_wr_data_i;
            if (wr_vld_q && !wr_grant) spi_ovf_d = 1'b1;
        end
        if (spi_rd_en_i) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = base + spi_rd_addr_i;
            if (rd_vld_q && !rd_grant) spi_ovf_d = 1'b1;
        end
    end

    // Arbitration also looks at incoming pulses so the local master never slips in ahead.
    always_comb begin
        state_d     = StArb;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        unique case (state_q)
            StArb: begin
                if (wr_vld_q || spi_wr_en_i) begin
                    state_d = StGSpiWr;
                end else if (rd_vld_q || spi_rd_en_i) begin
                    state_d = StGSpiRd;
                end else if (loc_req_i) begin
                    state_d = StGLoc;
                end
            end
            StGSpiWr: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = wr_addr_q;
                ram_wdata_d = wr_data_q;
            end
            StGSpiRd: begin
                ram_en_d   = 1'b1;
                ram_addr_d = rd_addr_q;
            end
            StGLoc: begin
                ram_en_d   = 1'b1;
                ram_we_d   = loc_we_i;
                ram_addr_d = loc_addr_i;
                if (loc_we_i) ram_wdata_d = loc_wdata_i;
            end
            default: state_d = StArb;
        endcase
    end

    assign tag_push   = rd_grant | (loc_grant & ~loc_we_i);
    assign tag_own_in = loc_grant ? OWN_LOC : OWN_SPI;

    spi_ram_rtag_pipe #(
        .RAM_LAT(RAM_LAT)
    ) u_rtag_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push_i(tag_push),
        .own_i (tag_own_in),
        .vld_o (tag_vld),
        .own_o (tag_own)
    );

    assign spi_hit = tag_vld & (tag_own == OWN_SPI);
    assign loc_hit = tag_vld & (tag_own == OWN_LOC);

    // Returning data bypasses the hold registers so it is visible in the RAM data cycle.
    assign spi_rd_data_o = spi_hit ? ram_rdata_i : spi_rd_data_q;
    assign loc_rdata_o   = loc_hit ? ram_rdata_i : loc_rdata_q;
    assign spi_rd_data_d = spi_rd_data_o;
    assign loc_rdata_d   = loc_rdata_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StArb;
            wr_vld_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_vld_q      <= 1'b0;
            rd_addr_q     <= '0;
            spi_ovf_q     <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            spi_rd_data_q <= '0;
            loc_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_vld_q      <= wr_vld_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_vld_q      <= rd_vld_d;
            rd_addr_q     <= rd_addr_d;
            spi_ovf_q     <= spi_ovf_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            spi_rd_data_q <= spi_rd_data_d;
            loc_rdata_q   <= loc_rdata_d;
        end
    end

    assign loc_gnt_o    = loc_grant;
    assign loc_rvalid_o = loc_hit;
    assign ram_en_o     = ram_en_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign spi_ovf_o    = spi_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter with a behavioural RAM of latency RAM_LAT.
module tb_spi_ram_arbiter;

    localparam int unsigned AW      = 9;
    localparam int unsigned DW      = 32;
    localparam int unsigned RAM_LAT = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [14:0]   spi_base = '0;
    logic          spi_wr_en = 1'b0;
    logic [AW-1:0] spi_wr_addr = '0;
    logic [DW-1:0] spi_wr_data = '0;
    logic          spi_rd_en = 1'b0;
    logic [AW-1:0] spi_rd_addr = '0;
    logic [DW-1:0] spi_rd_data;
    logic          loc_req = 1'b0;
    logic          loc_we = 1'b0;
    logic [AW-1:0] loc_addr = '0;
    logic [DW-1:0] loc_wdata = '0;
    logic          loc_gnt;
    logic          loc_rvalid;
    logic [DW-1:0] loc_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          spi_ovf;

    logic [DW-1:0] mem     [512];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] rpipe   [RAM_LAT];

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(
        .AW     (AW),
        .DW     (DW),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_base_i   (spi_base),
        .spi_wr_en_i  (spi_wr_en),
        .spi_wr_addr_i(spi_wr_addr),
        .spi_wr_data_i(spi_wr_data),
        .spi_rd_en_i  (spi_rd_en),
        .spi_rd_addr_i(spi_rd_addr),
        .spi_rd_data_o(spi_rd_data),
        .loc_req_i    (loc_req),
        .loc_we_i     (loc_we),
        .loc_addr_i   (loc_addr),
        .loc_wdata_i  (loc_wdata),
        .loc_gnt_o    (loc_gnt),
        .loc_rvalid_o (loc_rvalid),
        .loc_rdata_o  (loc_rdata),
        .ram_en_o     (ram_en),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
        .spi_ovf_o    (spi_ovf)
    );

    // Behavioural RAM: read data appears RAM_LAT cycles after the enable cycle.
    assign ram_rdata = rpipe[RAM_LAT-1];
    always @(posedge clk) begin
        if (ram_en && !ram_we) rpipe[0] <= mem[ram_addr];
        else                   rpipe[0] <= 32'hBAD0_BAD0;
        for (int i = 1; i < RAM_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        while (!(ram_en && ram_we) && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({ram_en, ram_we, loc_gnt, loc_rvalid, spi_ovf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {ram_en, ram_we, loc_gnt, loc_rvalid, spi_ovf});
        end
        total++;
        if (ram_addr !== '0 || ram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_ram_bus: got addr %h data %h want 0", ram_addr, ram_wdata);
        end
        total++;
        if (spi_rd_data !== '0 || loc_rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata: got spi %h loc %h want 0", spi_rd_data, loc_rdata);
        end
        tick();
        total++;
        if (ram_en !== 1'b0 || loc_gnt !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got en %b gnt %b want 0 0", ram_en, loc_gnt);
        end
    endtask

    task automatic test_spi_write();
        int  n;
        wr_t e;
        spi_base    = 15'h1F0;
        spi_wr_addr = 9'h020;
        spi_wr_data = 32'hDEAD_BEEF;
        spi_wr_en   = 1'b1;
        exp_wr.push_back({9'h010, 32'hDEAD_BEEF});
        ref_mem[9'h010] = 32'hDEAD_BEEF;
        tick();
        spi_wr_en = 1'b0;
        wait_wr(n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL wr_latency: got %0d want 2 cycles pulse-to-ram_en", n + 1);
        end
        if (n < 10) begin
            e = exp_wr.pop_front();
            total++;
            if (ram_addr !== e.a || ram_wdata !== e.d) begin
                bad++;
                $display("FAIL wr_wrap: got %h/%h want %h/%h", ram_addr, ram_wdata, e.a, e.d);
            end
        end else begin
            exp_wr.delete();
        end
        tick();
    endtask

    task automatic test_spi_read();
        logic [DW-1:0] e;
        spi_base    = 15'h0;
        spi_rd_addr = 9'd5;
        spi_rd_en   = 1'b1;
        exp_rd.push_back(ref_mem[5]);
        tick();
        spi_rd_en = 1'b0;
        tick();
        tick();
        total++;
        if (spi_rd_data !== '0) begin
            bad++;
            $display("FAIL rd_early: got %h want 00000000", spi_rd_data);
        end
        tick();
        e = exp_rd.pop_front();
        total++;
        if (spi_rd_data !== e) begin
            bad++;
            $display("FAIL spi_rd_data: got %h want %h", spi_rd_data, e);
        end
        tick();
        tick();
        total++;
        if (spi_rd_data !== e) begin
            bad++;
            $display("FAIL spi_rd_hold: got %h want %h", spi_rd_data, e);
        end
    endtask

    task automatic test_simul_wr_rd();
        int            n;
        wr_t           w;
        logic [DW-1:0] e;
        spi_base    = 15'h0;
        spi_wr_addr = 9'h0AB;
        spi_wr_data = 32'h5555_AAAA;
        spi_rd_addr = 9'h0AB;
        spi_wr_en   = 1'b1;
        spi_rd_en   = 1'b1;
        exp_wr.push_back({9'h0AB, 32'h5555_AAAA});
        ref_mem[9'h0AB] = 32'h5555_AAAA;
        exp_rd.push_back(ref_mem[9'h0AB]);
        tick();
        spi_wr_en = 1'b0;
        spi_rd_en = 1'b0;
        wait_wr(n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL simul_wr_first: got %0d want 1", n);
        end
        if (n < 10) begin
            w = exp_wr.pop_front();
            total++;
            if (ram_addr !== w.a || ram_wdata !== w.d) begin
                bad++;
                $display("FAIL simul_wr: got %h/%h want %h/%h", ram_addr, ram_wdata, w.a, w.d);
            end
        end else begin
            exp_wr.delete();
        end
        tick();
        tick();
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'h0AB) begin
            bad++;
            $display("FAIL simul_rd_issue: got en %b we %b addr %h want 1 0 0ab",
                     ram_en, ram_we, ram_addr);
        end
        tick();
        tick();
        e = exp_rd.pop_front();
        total++;
        if (spi_rd_data !== e) begin
            bad++;
            $display("FAIL simul_rd_data: got %h want %h", spi_rd_data, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wr_t w;
        int  wcyc[2];
        int  nw = 0;
        spi_base    = 15'h0;
        spi_wr_addr = 9'h100;
        spi_wr_data = 32'h0000_0101;
        spi_wr_en   = 1'b1;
        exp_wr.push_back({9'h100, 32'h0000_0101});
        exp_wr.push_back({9'h101, 32'h0000_0202});
        ref_mem[9'h100] = 32'h0000_0101;
        ref_mem[9'h101] = 32'h0000_0202;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                spi_wr_addr = 9'h101;
                spi_wr_data = 32'h0000_0202;
            end
            if (c == 2) spi_wr_en = 1'b0;
            if (ram_en && ram_we) begin
                if (nw < 2) wcyc[nw] = c;
                nw++;
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    total++;
                    if (ram_addr !== w.a || ram_wdata !== w.d) begin
                        bad++;
                        $display("FAIL b2b_wr: got %h/%h want %h/%h",
                                 ram_addr, ram_wdata, w.a, w.d);
                    end
                end
            end
            tick();
        end
        total++;
        if (nw !== 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 2", nw);
            exp_wr.delete();
        end else begin
            total++;
            if (wcyc[0] !== 2 || wcyc[1] !== 4) begin
                bad++;
                $display("FAIL b2b_timing: got %0d,%0d want 2,4", wcyc[0], wcyc[1]);
            end
        end
        total++;
        if (spi_ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_ovf: got %b want 0", spi_ovf);
        end
    endtask

    task automatic test_contention();
        wr_t w;
        int  gcyc = -1;
        int  ngnt = 0;
        int  nw = 0;
        bit  drop = 1'b0;
        spi_base    = 15'h0;
        spi_wr_addr = 9'h033;
        spi_wr_data = 32'h1111_2222;
        spi_wr_en   = 1'b1;
        loc_req     = 1'b1;
        loc_we      = 1'b1;
        loc_addr    = 9'h040;
        loc_wdata   = 32'h0BAD_F00D;
        exp_wr.push_back({9'h033, 32'h1111_2222});
        exp_wr.push_back({9'h040, 32'h0BAD_F00D});
        ref_mem[9'h033] = 32'h1111_2222;
        ref_mem[9'h040] = 32'h0BAD_F00D;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) spi_wr_en = 1'b0;
            if (drop) loc_req = 1'b0;
            if (ram_en && ram_we) begin
                nw++;
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    total++;
                    if (ram_addr !== w.a || ram_wdata !== w.d) begin
                        bad++;
                        $display("FAIL cont_wr_order: got %h/%h want %h/%h",
                                 ram_addr, ram_wdata, w.a, w.d);
                    end
                end
            end
            if (loc_gnt) begin
                if (gcyc < 0) gcyc = c;
                ngnt++;
                drop = 1'b1;
            end
            tick();
        end
        loc_req = 1'b0;
        total++;
        if (gcyc !== 3) begin
            bad++;
            $display("FAIL cont_gnt_cycle: got %0d want 3", gcyc);
        end
        total++;
        if (ngnt !== 1 || nw !== 2) begin
            bad++;
            $display("FAIL cont_counts: got gnt %0d wr %0d want 1 2", ngnt, nw);
            exp_wr.delete();
        end
    endtask

    task automatic test_loc_read();
        logic [DW-1:0] e;
        int            gcyc = -1;
        int            rcyc = -1;
        int            nr = 0;
        bit            drop = 1'b0;
        loc_req  = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 9'h1FF;
        exp_rd.push_back(ref_mem[9'h1FF]);
        for (int c = 0; c < 10; c++) begin
            if (drop) loc_req = 1'b0;
            if (loc_gnt && gcyc < 0) begin
                gcyc = c;
                drop = 1'b1;
            end
            if (loc_rvalid) begin
                rcyc = c;
                nr++;
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    total++;
                    if (loc_rdata !== e) begin
                        bad++;
                        $display("FAIL loc_rdata: got %h want %h", loc_rdata, e);
                    end
                end
            end
            tick();
        end
        loc_req = 1'b0;
        total++;
        if (gcyc < 0 || rcyc - gcyc !== 3) begin
            bad++;
            $display("FAIL loc_rd_latency: got gnt %0d rvalid %0d want gap 3", gcyc, rcyc);
        end
        total++;
        if (nr !== 1) begin
            bad++;
            $display("FAIL loc_rvalid_count: got %0d want 1", nr);
            exp_rd.delete();
        end
    endtask

    task automatic test_overflow();
        wr_t           w;
        logic [DW-1:0] e;
        int            nw = 0;
        spi_base    = 15'h0;
        spi_rd_addr = 9'd7;
        spi_rd_en   = 1'b1;
        exp_rd.push_back(ref_mem[7]);
        tick();
        spi_rd_en   = 1'b0;
        spi_wr_addr = 9'h060;
        spi_wr_data = 32'hAAAA_0001;
        spi_wr_en   = 1'b1;
        tick();
        total++;
        if (spi_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_first_pulse: got %b want 0", spi_ovf);
        end
        spi_wr_addr = 9'h061;
        spi_wr_data = 32'hAAAA_0002;
        exp_wr.push_back({9'h061, 32'hAAAA_0002});
        ref_mem[9'h061] = 32'hAAAA_0002;
        tick();
        spi_wr_en = 1'b0;
        total++;
        if (spi_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got %b want 1", spi_ovf);
        end
        for (int c = 3; c < 10; c++) begin
            if (c == 4) begin
                e = exp_rd.pop_front();
                total++;
                if (spi_rd_data !== e) begin
                    bad++;
                    $display("FAIL ovf_rd_data: got %h want %h", spi_rd_data, e);
                end
            end
            if (ram_en && ram_we) begin
                nw++;
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    total++;
                    if (ram_addr !== w.a || ram_wdata !== w.d) begin
                        bad++;
                        $display("FAIL ovf_last_kept: got %h/%h want %h/%h",
                                 ram_addr, ram_wdata, w.a, w.d);
                    end
                end
            end
            tick();
        end
        total++;
        if (nw !== 1 || spi_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_writes_sticky: got wr %0d ovf %b want 1 1", nw, spi_ovf);
            exp_wr.delete();
        end
    endtask

    task automatic test_rst_mid();
        int nrv = 0;
        loc_req  = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 9'h0AB;
        tick();
        total++;
        if (loc_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_gnt: got %b want 1", loc_gnt);
        end
        tick();
        loc_req = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({ram_en, ram_we, loc_gnt, loc_rvalid, spi_ovf} !== 5'b0 || ram_addr !== '0 ||
            ram_wdata !== '0 || spi_rd_data !== '0 || loc_rdata !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got ctl %b addr %h wd %h spi %h loc %h want 0",
                     {ram_en, ram_we, loc_gnt, loc_rvalid, spi_ovf}, ram_addr, ram_wdata,
                     spi_rd_data, loc_rdata);
        end
        for (int c = 0; c < 6; c++) begin
            if (loc_rvalid) nrv++;
            tick();
        end
        total++;
        if (nrv !== 0) begin
            bad++;
            $display("FAIL rst_drops_read: got %0d rvalid pulses want 0", nrv);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = {16'h5A5A ^ i[15:0], i[15:0]};
            ref_mem[i] = {16'h5A5A ^ i[15:0], i[15:0]};
        end
        mem[5]          = 32'h1234_5678;
        ref_mem[5]      = 32'h1234_5678;
        mem[9'h1FF]     = 32'hCAFE_F00D;
        ref_mem[9'h1FF] = 32'hCAFE_F00D;

        test_reset();
        test_spi_write();
        test_spi_read();
        test_simul_wr_rd();
        test_back_to_back();
        test_contention();
        test_loc_read();
        test_overflow();
        test_rst_mid();

        total++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got wr %0d rd %0d left want 0 0",
                     exp_wr.size(), exp_rd.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
